// File: rtl/isqrt_seq.sv
// rtl/isqrt_seq.sv - sequential restoring integer square root, one root bit per clock
// Q = floor(sqrt(X)), R = X - Q*Q, with valid/ready handshakes on input and result.
module isqrt_seq #(
  parameter int LEN = 32,
  localparam int QLEN = LEN / 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LEN-1:0]  X,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [QLEN-1:0] Q,
  output logic [QLEN:0]   R
);

  localparam int RW = QLEN + 2;
  localparam int CW = (QLEN > 1) ? $clog2(QLEN) : 1;

  if (LEN < 2 || (LEN % 2) != 0) begin : g_bad_len
    $error("isqrt_seq: LEN must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LEN-1:0]  x_q, x_d;
  logic [QLEN-1:0] q_q, q_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [QLEN-1:0] q_out_q, q_out_d;
  logic [QLEN:0]   r_out_q, r_out_d;

  logic [RW-1:0]   rem_sh;
  logic [RW-1:0]   sub;
  logic [RW-1:0]   trial;
  logic            ge;

  // Bring down the next two radicand bits and test against 4*q + 1.
  assign rem_sh = (rem_q << 2) | RW'(x_q[LEN-1 -: 2]);
  assign sub    = {q_q, 2'b01};
  assign trial  = rem_sh - sub;
  assign ge     = (rem_sh >= sub);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    q_d       = q_q;
    rem_d     = rem_q;
    q_out_d   = q_out_q;
    r_out_d   = r_out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = X;
          cnt_d   = CW'(QLEN - 1);
          q_d     = '0;
          rem_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        x_d   = x_q << 2;
        q_d   = (q_q << 1) | QLEN'(ge);
        rem_d = ge ? trial : rem_sh;
        if (cnt_q == '0) begin
          // Results are captured separately so they survive the next run.
          q_out_d = q_d;
          r_out_d = rem_d[QLEN:0];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
    end
  end

  assign Q = q_out_q;
  assign R = r_out_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// tb/tb_isqrt_seq.sv - scoreboard bench for isqrt_seq at LEN=32, 8 and 2
module tb_isqrt_seq;

  localparam int LEN  = 32;
  localparam int QLEN = LEN / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [LEN-1:0]  x;
  logic [QLEN-1:0] q;
  logic [QLEN:0]   r;

  int total = 0;
  int bad   = 0;
  bit rand_go = 1'b0;
  bit rand_main = 1'b0;
  bit [1:0] small_done = 2'b00;

  isqrt_seq #(.LEN(LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(x),
    .out_valid(out_valid), .out_ready(out_ready), .Q(q), .R(r)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: floor square root from real sqrt, corrected by exact integer tests.
  function automatic longint isqrt_ref(input longint v);
    longint s;
    s = longint'($sqrt(real'(v)));
    while (s * s > v) s--;
    while ((s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Main scoreboard: expected values pushed on acceptance, popped on handoff.
  longint exp_q[$];
  longint exp_r[$];
  longint ms;
  logic [QLEN-1:0] hold_q;
  logic [QLEN:0]   hold_r;
  bit stall_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_r.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_q", q, hold_q);
        check("hold_r", r, hold_r);
      end
      if (in_valid && in_ready) begin
        ms = isqrt_ref(longint'(x));
        exp_q.push_back(ms);
        exp_r.push_back(longint'(x) - ms * ms);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_result", 1, 0);
        else begin
          check("res_q", q, exp_q.pop_front());
          check("res_r", r, exp_r.pop_front());
        end
        stall_prev = 1'b0;
      end else if (out_valid) begin
        stall_prev = 1'b1;
        hold_q = q;
        hold_r = r;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_small
    localparam int L  = (g == 0) ? 8 : 2;
    localparam int QL = L / 2;
    logic          iv, ir, ov, ordy;
    logic [L-1:0]  xs;
    logic [QL-1:0] qs;
    logic [QL:0]   rs;
    longint eq[$];
    longint er[$];
    longint s;

    isqrt_seq #(.LEN(L)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .X(xs),
      .out_valid(ov), .out_ready(ordy), .Q(qs), .R(rs)
    );

    always @(negedge clk) begin
      if (rst) begin
        eq.delete();
        er.delete();
      end else begin
        if (iv && ir) begin
          s = isqrt_ref(longint'(xs));
          eq.push_back(s);
          er.push_back(longint'(xs) - s * s);
        end
        if (ov && ordy) begin
          if (eq.size() == 0) check($sformatf("L%0d_spurious", L), 1, 0);
          else begin
            check($sformatf("L%0d_q", L), qs, eq.pop_front());
            check($sformatf("L%0d_r", L), rs, er.pop_front());
          end
        end
      end
    end

    initial begin
      iv = 1'b0;
      ordy = 1'b0;
      xs = '0;
      wait (rand_go);
      for (int i = 0; i < 6000; i++) begin
        step();
        iv   = 1'($urandom_range(0, 1));
        ordy = 1'($urandom_range(0, 1));
        xs   = L'($urandom);
      end
      iv = 1'b0;
      ordy = 1'b1;
      repeat (L + 6) step();
      check($sformatf("L%0d_drained", L), eq.size(), 0);
      small_done[g] = 1'b1;
    end
  end

  initial begin
    forever begin
      step();
      if (rand_main) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
          0: x = '0;
          1: x = '1;
          default: x = $urandom;
        endcase
      end
    end
  end

  task automatic directed(input logic [LEN-1:0] xv, input longint eq_v, input longint er_v,
                          input string nm);
    int k;
    check({nm, "_idle_before"}, in_ready, 1);
    x = xv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({nm, "_in_ready_run"}, in_ready, 0);
    k = 0;
    while (!out_valid && k < 100) begin
      step();
      k++;
    end
    check({nm, "_latency"}, k, QLEN);
    check({nm, "_q"}, q, eq_v);
    check({nm, "_r"}, r, er_v);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({nm, "_idle_after"}, in_ready, 1);
    check({nm, "_valid_after"}, out_valid, 0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    repeat (3) step();
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_q", q, 0);
    check("reset_r", r, 0);
    rst = 1'b0;
    step();

    directed(32'd0, 0, 0, "x0");
    directed(32'd99, 9, 18, "x99");
    directed(32'd1000000, 1000, 0, "x1e6");
    directed(32'hFFFF_FFFF, 64'h0000_FFFF, 64'h0001_FFFE, "xmax");

    // Backpressure with input noise while the result waits.
    x = 32'd12345;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      step();
      k++;
    end
    for (int i = 0; i < 20; i++) begin
      x = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      step();
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_q", q, 111);
      check("bp_r", r, 24);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Abort mid-run after five iterations.
    x = 32'd1000000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    directed(32'd16, 4, 0, "x16");

    rand_go = 1'b1;
    rand_main = 1'b1;
    repeat (30000) step();
    rand_main = 1'b0;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 200) begin
      step();
      k++;
    end
    check("main_drained", exp_q.size(), 0);
    k = 0;
    while (small_done != 2'b11 && k < 20000) begin
      step();
      k++;
    end
    check("small_finished", small_done, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
